// File: rtl/ws2811_decoder.sv
// ws2811_decoder
//   Recovers 24-bit pixels from a WS2811 single-wire pulse-width stream.
//   Each bit is a high pulse whose width selects 0 or 1. A long low gap
//   ends a frame (latch). Decoded pixels are re-ordered according to the
//   channel-order code and offered on a valid/ready output.
//
// Parameters
//   BIT_THRESH_CYC : high clocks at or above which a bit is a 1
//   MIN_HIGH_CYC   : high clocks below which a pulse is an error
//   MAX_HIGH_CYC   : high clocks above which a pulse is an error
//   RESET_CYC      : low clocks that form a latch/reset gap
//
// Ports
//   clkIN          in   clock, rising edge
//   nResetIN       in   asynchronous active-low reset
//   serialIN       in   asynchronous WS2811 data line
//   swapIN[2:0]    in   channel-order code, sampled when a pixel loads
//   dataOUT[23:0]  out  decoded, un-swapped pixel
//   validOUT       out  dataOUT holds an unconsumed pixel
//   readyIN        in   consumer accepts dataOUT
//   latchOUT       out  one-cycle pulse at end of frame
//   errorOUT       out  one-cycle pulse on a protocol error
//   overflowOUT    out  one-cycle pulse when a completed pixel is dropped
//   pixelCountOUT  out  pixels completed since the last latch (saturating)

module ws2811_decoder #(
  parameter int BIT_THRESH_CYC = 22,
  parameter int MIN_HIGH_CYC   = 4,
  parameter int MAX_HIGH_CYC   = 60,
  parameter int RESET_CYC      = 2500
) (
  input  logic        clkIN,
  input  logic        nResetIN,
  input  logic        serialIN,
  input  logic [2:0]  swapIN,
  output logic [23:0] dataOUT,
  output logic        validOUT,
  input  logic        readyIN,
  output logic        latchOUT,
  output logic        errorOUT,
  output logic        overflowOUT,
  output logic [15:0] pixelCountOUT
);

  localparam int HW = $clog2(MAX_HIGH_CYC + 2);
  localparam int LW = $clog2(RESET_CYC + 1);

  localparam logic [HW-1:0] H_MIN = HW'(MIN_HIGH_CYC);
  localparam logic [HW-1:0] H_THR = HW'(BIT_THRESH_CYC);
  localparam logic [HW-1:0] H_MAX = HW'(MAX_HIGH_CYC);
  localparam logic [HW-1:0] H_ONE = HW'(1);
  localparam logic [LW-1:0] L_RST = LW'(RESET_CYC);
  localparam logic [LW-1:0] L_ONE = LW'(1);

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_t;

  state_t        state, state_n;
  logic          sync1, sync2, line_q;
  logic [HW-1:0] high_cnt, high_n;
  logic [LW-1:0] low_cnt, low_n, low_inc;
  logic [4:0]    bit_cnt, bit_n;
  logic [23:0]   word, word_n;
  logic [23:0]   data_q, data_n;
  logic          valid_q, valid_n;
  logic          latch_n, error_n, ovf_n;
  logic          latch_q, error_q, ovf_q;
  logic [15:0]   pix_cnt, pix_n;

  logic          rise, fall;
  logic          bit_ok, bit_val, pixel_done;
  logic [23:0]   pixel_word;

  function automatic logic [23:0] unswap(input logic [23:0] w, input logic [2:0] code);
    case (code)
      3'b001:  unswap = {w[23:16], w[7:0],   w[15:8]};
      3'b010:  unswap = {w[7:0],   w[15:8],  w[23:16]};
      3'b011:  unswap = {w[15:8],  w[7:0],   w[23:16]};
      3'b100:  unswap = {w[7:0],   w[23:16], w[15:8]};
      3'b101:  unswap = {w[15:8],  w[23:16], w[7:0]};
      default: unswap = w;
    endcase
  endfunction

  assign rise = sync2 & ~line_q;
  assign fall = ~sync2 & line_q;

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      line_q   <= 1'b0;
      state    <= ST_SYNC;
      high_cnt <= '0;
      low_cnt  <= '0;
      bit_cnt  <= '0;
      word     <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      latch_q  <= 1'b0;
      error_q  <= 1'b0;
      ovf_q    <= 1'b0;
      pix_cnt  <= '0;
    end else begin
      sync1    <= serialIN;
      sync2    <= sync1;
      line_q   <= sync2;
      state    <= state_n;
      high_cnt <= high_n;
      low_cnt  <= low_n;
      bit_cnt  <= bit_n;
      word     <= word_n;
      data_q   <= data_n;
      valid_q  <= valid_n;
      latch_q  <= latch_n;
      error_q  <= error_n;
      ovf_q    <= ovf_n;
      pix_cnt  <= pix_n;
    end
  end

  always_comb begin
    state_n    = state;
    high_n     = high_cnt;
    low_n      = low_cnt;
    bit_n      = bit_cnt;
    word_n     = word;
    latch_n    = 1'b0;
    error_n    = 1'b0;
    bit_ok     = 1'b0;
    bit_val    = 1'b0;
    pixel_done = 1'b0;
    pixel_word = '0;
    low_inc    = (low_cnt == L_RST) ? L_RST : low_cnt + L_ONE;

    case (state)
      ST_SYNC: begin
        if (sync2) begin
          low_n = '0;
        end else begin
          low_n = low_inc;
          if (low_inc == L_RST) state_n = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (rise) begin
          state_n = ST_HIGH;
          high_n  = H_ONE;
        end
      end
      ST_HIGH: begin
        if (sync2) begin
          // Over-long pulse is flagged as soon as the count passes the limit.
          if (high_cnt >= H_MAX) begin
            high_n  = H_MAX + H_ONE;
            error_n = 1'b1;
          end else begin
            high_n = high_cnt + H_ONE;
          end
        end else if (fall) begin
          if (high_cnt < H_MIN || high_cnt > H_MAX) begin
            error_n = 1'b1;
          end else begin
            bit_ok  = 1'b1;
            bit_val = (high_cnt >= H_THR);
          end
          state_n = ST_LOW;
          low_n   = L_ONE;
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_n = ST_HIGH;
          high_n  = H_ONE;
        end else begin
          low_n = low_inc;
          if (low_inc == L_RST) begin
            latch_n = 1'b1;
            state_n = ST_IDLE;
            if (bit_cnt != 5'd0) error_n = 1'b1;
          end
        end
      end
      default: state_n = ST_SYNC;
    endcase

    if (bit_ok) begin
      if (bit_cnt == 5'd23) begin
        pixel_done = 1'b1;
        pixel_word = {word[22:0], bit_val};
        bit_n      = '0;
        word_n     = '0;
      end else begin
        word_n = {word[22:0], bit_val};
        bit_n  = bit_cnt + 5'd1;
      end
    end

    // Errors drop the partial pixel and force a resync. A latch-time error
    // keeps the saturated low count so SYNC releases to IDLE on the next
    // clock while the line stays low.
    if (error_n) begin
      bit_n   = '0;
      word_n  = '0;
      state_n = ST_SYNC;
      if (!latch_n) low_n = '0;
    end
  end

  always_comb begin
    data_n  = data_q;
    valid_n = valid_q;
    ovf_n   = 1'b0;
    pix_n   = pix_cnt;

    if (valid_q && readyIN) valid_n = 1'b0;

    if (pixel_done) begin
      if (!valid_q || readyIN) begin
        data_n  = unswap(pixel_word, swapIN);
        valid_n = 1'b1;
      end else begin
        ovf_n = 1'b1;
      end
    end

    if (latch_n) begin
      pix_n = '0;
    end else if (pixel_done && pix_cnt != '1) begin
      pix_n = pix_cnt + 16'd1;
    end
  end

  assign dataOUT       = data_q;
  assign validOUT      = valid_q;
  assign latchOUT      = latch_q;
  assign errorOUT      = error_q;
  assign overflowOUT   = ovf_q;
  assign pixelCountOUT = pix_cnt;

endmodule
